// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-slot ghost blanking.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking on digits 1..3.

module seg_hex_dec (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end
endmodule

module seg_scan_driver #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] din,
   input  logic        cin,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);
   localparam int NUM_DIGITS = 4;
   localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_L  = DIV_W'(BLANK_CYC);

   logic [DIV_W-1:0]                 div_cnt;
   logic [1:0]                       idx;
   logic [15:0]                      val_q;
   logic                             cout_q;
   logic [NUM_DIGITS-1:0][6:0]       dig_seg;
   logic [3:0]                       an_d;
   logic [6:0]                       seg_d;
   logic                             dp_d;

   // All digits decode in parallel; the scan index just picks one.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg_hex_dec u_dec (.nib(val_q[4*g +: 4]), .seg(dig_seg[g]));
   end

`ifdef SEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lead_zero;
   assign lead_zero[0] = 1'b0;
   for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lz
      assign lead_zero[g] = ~|val_q[15:4*g];
   end
`endif

   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (div_cnt >= BLANK_L) begin
         an_d[idx] = 1'b0;
         seg_d     = dig_seg[idx];
         dp_d      = ~(cout_q && (idx == 2'd3));
`ifdef SEG_SCAN_LZB_EN
         // A blanked digit 3 still lights its anode when the carry dot is on.
         if (lead_zero[idx]) begin
            seg_d = 7'h7F;
            an_d  = 4'b1111;
            if (idx == 2'd3 && cout_q) an_d[3] = 1'b0;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         idx     <= 2'd0;
         val_q   <= 16'h0000;
         cout_q  <= 1'b0;
         an      <= 4'b1111;
         seg     <= 7'h7F;
         dp      <= 1'b1;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         if (load) begin
            val_q  <= din;
            cout_q <= cin;
         end
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: scan-position model plus directed literal checks.
module tb_seg_scan_driver;
   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] din = 16'h0000;
   logic        cin = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int tests = 0;
   int fails = 0;

   seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk(clk), .reset(reset), .load(load), .din(din), .cin(cin),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Output after a non-reset edge reflects scan position p = edges since reset.
   function automatic logic [11:0] model_out(int p, logic [15:0] v, logic c);
      int ph, sl;
      logic [3:0] a, nib;
      logic [6:0] s;
      logic d;
      ph = p % CLK_DIV;
      sl = (p / CLK_DIV) % 4;
      if (ph < BLANK_CYC) return 12'hFFF;
      a = 4'hF;
      a[sl] = 1'b0;
      nib = 4'(v >> (4 * sl));
      s = hex_tab[nib];
      d = !(sl == 3 && c);
`ifdef SEG_SCAN_LZB_EN
      if (sl > 0 && (v >> (4 * sl)) == 16'h0) begin
         s = 7'h7F;
         a = (sl == 3 && c) ? 4'b0111 : 4'b1111;
      end
`endif
      return {a, s, d};
   endfunction

   int          n = 0;
   logic [15:0] mval = 16'h0;
   logic        mcout = 1'b0;
   logic        mvalid = 1'b0;
   logic [11:0] exp_o = 12'hFFF;

   always @(posedge clk) begin
      if (reset) begin
         n <= 0; mval <= 16'h0; mcout <= 1'b0; exp_o <= 12'hFFF; mvalid <= 1'b1;
      end else begin
         exp_o <= model_out(n, mval, mcout);
         n <= n + 1;
         if (load) begin
            mval <= din; mcout <= cin;
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (mvalid) check("model an/seg/dp", {4'h0, an, seg, dp}, {4'h0, exp_o});
   endtask

   logic [3:0] an2  [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                             4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
   logic [6:0] seg2 [16] = '{7'h0E, 7'h0E, 7'h0E, 7'h7F, 7'h24, 7'h24, 7'h24, 7'h7F,
                             7'h08, 7'h08, 7'h08, 7'h7F, 7'h79, 7'h79, 7'h79, 7'h7F};

   initial begin
      int cnt, cnt2, cnt3;
      bit found;
      // Reset held 3 cycles, then first SHOW on the second edge after release
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset an", 16'(an), 16'hF);
         check("reset seg", 16'(seg), 16'h7F);
         check("reset dp", 16'(dp), 16'h1);
      end
      reset = 1'b0;
      tick();
      check("post-reset blank an", 16'(an), 16'hF);
      tick();
      check("first show an", 16'(an), 16'hE);
      check("first show seg", 16'(seg), 16'h40);

      // Scan order with 0x1A2F
      reset = 1'b1;
      tick();
      reset = 1'b0; load = 1'b1; din = 16'h1A2F; cin = 1'b0;
      tick();
      load = 1'b0;
      for (int j = 0; j < 16; j++) begin
         tick();
         check($sformatf("scan an[%0d]", j), 16'(an), 16'(an2[j]));
         check($sformatf("scan seg[%0d]", j), 16'(seg), 16'(seg2[j]));
         check($sformatf("scan dp[%0d]", j), 16'(dp), 16'h1);
      end

      // Load mid-slot while digit 0 shows F
      tick();
      check("period repeat an", 16'(an), 16'hE);
      check("period repeat seg", 16'(seg), 16'h0E);
      load = 1'b1; din = 16'h0003;
      tick();
      load = 1'b0;
      check("capture edge seg", 16'(seg), 16'h0E);
      tick();
      check("midslot new seg", 16'(seg), 16'h30);
      check("midslot an", 16'(an), 16'hE);
      tick();
      check("slot boundary blank", 16'(an), 16'hF);
      tick();
`ifdef SEG_SCAN_LZB_EN
      check("digit1 lzb an", 16'(an), 16'hF);
`else
      check("digit1 an", 16'(an), 16'hD);
      check("digit1 seg", 16'(seg), 16'h40);
`endif

      // Carry on digit-3 dp only
      load = 1'b1; din = 16'hFFFF; cin = 1'b1;
      tick();
      load = 1'b0;
      cnt = 0; cnt2 = 0;
      for (int j = 0; j < 16; j++) begin
         tick();
         if (dp === 1'b0) begin
            cnt++;
            if (an !== 4'b0111) cnt2++;
         end
      end
      check("carry dp low cycles", 16'(cnt), 16'd3);
      check("carry dp off-digit", 16'(cnt2), 16'd0);

      // Reset mid-scan at idx=2
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         tick();
         if (an === 4'b1011) found = 1'b1;
      end
      check("reach digit2", 16'(found), 16'h1);
      reset = 1'b1;
      tick();
      check("midscan reset an", 16'(an), 16'hF);
      check("midscan reset seg", 16'(seg), 16'h7F);
      reset = 1'b0;
      tick();
      tick();
      check("resume an", 16'(an), 16'hE);
      check("resume seg", 16'(seg), 16'h40);
      check("resume dp", 16'(dp), 16'h1);

`ifdef SEG_SCAN_LZB_EN
      reset = 1'b1;
      tick();
      reset = 1'b0; load = 1'b1; din = 16'h0050; cin = 1'b0;
      tick();
      load = 1'b0;
      cnt = 0; cnt2 = 0; cnt3 = 0;
      for (int j = 0; j < 16; j++) begin
         tick();
         if (an === 4'hE && seg === 7'h40) cnt++;
         if (an === 4'hD && seg === 7'h12) cnt2++;
         if (an === 4'hB || an === 4'h7) cnt3++;
      end
      check("lzb digit0", 16'(cnt), 16'd3);
      check("lzb digit1", 16'(cnt2), 16'd3);
      check("lzb upper off", 16'(cnt3), 16'd0);
      load = 1'b1; din = 16'h0000; cin = 1'b1;
      tick();
      load = 1'b0;
      cnt = 0; cnt2 = 0;
      for (int j = 0; j < 16; j++) begin
         tick();
         if (an === 4'hE && seg === 7'h40) cnt++;
         if (an === 4'h7 && seg === 7'h7F && dp === 1'b0) cnt2++;
      end
      check("lzb zero digit0", 16'(cnt), 16'd3);
      check("lzb carry dot", 16'(cnt2), 16'd3);
`else
      cnt3 = 0;
      check("no-lzb upper slot count", 16'(cnt3), 16'd0);
`endif

      for (int j = 0; j < 8; j++) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage for the 16-bit register/adder datapath. It latches the 16-bit sum and carry on a load strobe and time-multiplexes them onto one shared 4-digit common-anode seven-segment display. Digit scanning is driven by a refresh counter, with per-slot ghost blanking. It replaces four parallel decoders driving four static displays.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot; legal range 4 to 2^20.
BLANK_CYC, 2, cycles at the start of each slot with all anodes off; must be less than CLK_DIV.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
load  input  1  when high at a clk edge, capture din and cin
din  input  16  value to display; [3:0] is digit 0 (rightmost)
cin  input  1  adder carry-out, shown on the digit-3 decimal point
an  output  4  digit anode enables, active-low; an[k] selects digit k
seg  output  7  segments, active-low; seg[0]=a … seg[6]=g
dp  output  1  decimal point, active-low

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. Reset is synchronous and active-high and overrides load.
- Reset values:
  - internal: div_cnt=0, idx=0, val_q=16'h0000, cout_q=0
  - outputs: an=4'b1111, seg=7'b1111111, dp=1
- Holding register:
  - load=1 at edge N: val_q<=din and cout_q<=cin at edge N.
  - The new value appears on seg/dp at edge N+1 if its digit is currently selected and unblanked.
  - load held high recaptures every cycle. din/cin are ignored when load=0.
- Refresh counter:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - On wrap, idx advances 0→1→2→3→0.
  - load does not disturb div_cnt or idx.
- Slot phases, decided by div_cnt:
  - div_cnt < BLANK_CYC: BLANK phase.
  - otherwise: SHOW phase.
- Registered outputs (one cycle after div_cnt/idx):
  - BLANK: an=4'b1111, seg=7'h7F, dp=1.
  - SHOW: an = one-hot-low of idx; seg = hex code of nibble val_q[4*idx+3:4*idx]; dp = ~cout_q when idx==3, else 1.
- Hex codes (gfedcba, active-low, hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- At most one an bit is low in any cycle. There are no glitches between slots because outputs are registered.
- Reset mid-scan: returns to the reset values at the next edge. Scanning restarts at idx=0 with BLANK phase.
- Full scan period is 4*CLK_DIV cycles. Each digit's duty is (CLK_DIV-BLANK_CYC)/(4*CLK_DIV).

Optional Feature:
Macro SEG_SCAN_LZB_EN.
- Defined (leading-zero blanking): during SHOW for digit k>0, force an=4'b1111 and seg=7'h7F when val_q[15:4*k] is all zero.
  - Digit 0 is always shown, so 0x0000 displays "0".
  - dp still follows cout_q on digit 3: if cout_q=1 and digit 3 would be blanked, an[3] is driven low with seg=7'h7F and dp=0.
- Not defined: all four digits are always shown, including leading zeros.

Test Plan:
1. Reset: assert reset 3 cycles with CLK_DIV=4, BLANK_CYC=1 → an=1111, seg=7F, dp=1. After release, first SHOW output is an=1110, seg=40 at cycle 2.
2. Scan order, CLK_DIV=4, BLANK_CYC=1, load 0x1A2F, cin=0:
   - an sequence per slot is 1111 then 1110/1101/1011/0111.
   - seg is 0E, 24, 08, 79 respectively.
   - dp=1 throughout.
   - Period is 16 cycles.
3. Load mid-slot: while digit 0 shows F, pulse load with din=0x0003 → seg changes to 30 exactly one cycle after the capturing edge. div_cnt and idx are unchanged.
4. Carry: load 0xFFFF with cin=1 → dp=0 only in digit-3 SHOW cycles, and dp=1 in all BLANK and other-digit cycles.
5. Reset mid-scan: assert reset while idx=2 → next edge gives an=1111. Scan resumes from digit 0 and val_q reads 0000.
6. SEG_SCAN_LZB_EN defined, load 0x0050, cin=0 → digits 0 and 1 show 40 and 12. Digit 2 and 3 slots keep an=1111. Then load 0x0000 with cin=1 → digit 0 shows 40, digit 3 slot has an=0111, seg=7F, dp=0.
